// File: rtl/i2c_spi_bridge_sequencer.sv
// I2C-to-SPI bridge sequencer: decodes the control byte of each I2C write session,
// frames SPI byte transfers with chip-select setup/hold and buffers MISO bytes for read-back.
module i2c_spi_bridge_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int CS_SETUP   = 2,
    parameter int CS_HOLD    = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i2c_start,
    input  logic                          i2c_rnw,
    input  logic                          i2c_stop,
    input  logic                          i2c_wr_valid,
    input  logic [7:0]                    i2c_wr_data,
    output logic                          i2c_wr_ready,
    input  logic                          i2c_rd_req,
    output logic [7:0]                    i2c_rd_data,
    output logic                          spi_start,
    output logic [7:0]                    spi_tx_data,
    input  logic                          spi_done,
    input  logic [7:0]                    spi_rx_data,
    output logic [3:0]                    spi_cs_n,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow
);

    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int LW   = AW + 1;
    localparam int CMAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_CS_SETUP,
        ST_READY,
        ST_XFER,
        ST_CS_HOLD
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            discard_q, discard_d;
    logic            end_pending_q, end_pending_d;
    logic            restart_pending_q, restart_pending_d;
    logic [3:0]      spi_cs_n_q, spi_cs_n_d;
    logic            spi_start_q, spi_start_d;
    logic [7:0]      spi_tx_data_q, spi_tx_data_d;
    logic            i2c_wr_ready_q, i2c_wr_ready_d;
    logic [7:0]      i2c_rd_data_q, i2c_rd_data_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic            overflow_q, overflow_d;
    logic [7:0]      fifo_mem_q [FIFO_DEPTH];

    logic fifo_clr, push_req, do_push, do_pop, fifo_empty, fifo_full;
    logic wr_accept, sess_end, start_w, in_session;

    assign wr_accept  = i2c_wr_valid & i2c_wr_ready_q;
    assign sess_end   = i2c_stop | i2c_start;
    assign start_w    = i2c_start & ~i2c_rnw;
    assign in_session = (state_q == ST_CMD) || (state_q == ST_CS_SETUP) ||
                        (state_q == ST_READY) || (state_q == ST_XFER);

    always_comb begin
        state_d           = state_q;
        cnt_d             = cnt_q;
        discard_d         = discard_q;
        end_pending_d     = end_pending_q;
        restart_pending_d = restart_pending_q;
        spi_cs_n_d        = spi_cs_n_q;
        spi_start_d       = 1'b0;
        spi_tx_data_d     = spi_tx_data_q;
        fifo_clr          = 1'b0;
        push_req          = 1'b0;

        if (in_session && sess_end) begin
            end_pending_d     = 1'b1;
            restart_pending_d = restart_pending_q | start_w;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_w) begin
                    state_d  = ST_CMD;
                    fifo_clr = 1'b1;
                end
            end
            ST_CMD: begin
                // CS is not yet asserted, so a session end needs no hold phase
                if (sess_end) begin
                    state_d           = start_w ? ST_CMD : ST_IDLE;
                    fifo_clr          = start_w;
                    end_pending_d     = 1'b0;
                    restart_pending_d = 1'b0;
                end else if (wr_accept) begin
                    discard_d  = i2c_wr_data[7];
                    spi_cs_n_d = ~(4'b0001 << i2c_wr_data[1:0]);
                    cnt_d      = '0;
                    state_d    = ST_CS_SETUP;
                end
            end
            ST_CS_SETUP: begin
                if (end_pending_d) begin
                    cnt_d   = '0;
                    state_d = ST_CS_HOLD;
                end else if (cnt_q == CW'(CS_SETUP - 1)) begin
                    state_d = ST_READY;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_READY: begin
                if (wr_accept) begin
                    spi_tx_data_d = i2c_wr_data;
                    spi_start_d   = 1'b1;
                    state_d       = ST_XFER;
                end else if (end_pending_d) begin
                    cnt_d   = '0;
                    state_d = ST_CS_HOLD;
                end
            end
            ST_XFER: begin
                if (spi_done) begin
                    push_req = ~discard_q;
                    if (end_pending_d) begin
                        cnt_d   = '0;
                        state_d = ST_CS_HOLD;
                    end else begin
                        state_d = ST_READY;
                    end
                end
            end
            ST_CS_HOLD: begin
                if (cnt_q == CW'(CS_HOLD - 1)) begin
                    spi_cs_n_d        = 4'b1111;
                    state_d           = restart_pending_q ? ST_CMD : ST_IDLE;
                    fifo_clr          = restart_pending_q;
                    end_pending_d     = 1'b0;
                    restart_pending_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        i2c_wr_ready_d = (state_d == ST_CMD) || (state_d == ST_READY);
    end

    // A pop frees a slot in the same cycle, so a push into a full FIFO still lands
    always_comb begin
        fifo_empty    = (level_q == '0);
        fifo_full     = (level_q == LW'(FIFO_DEPTH));
        do_pop        = i2c_rd_req & ~fifo_empty;
        do_push       = push_req & (~fifo_full | do_pop);
        i2c_rd_data_d = i2c_rd_data_q;
        if (i2c_rd_req) begin
            i2c_rd_data_d = fifo_empty ? 8'hFF : fifo_mem_q[rd_ptr_q];
        end
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        if (fifo_clr) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            level_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            level_d = level_q + LW'(do_push) - LW'(do_pop);
            if (push_req && fifo_full && !do_pop) overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !fifo_clr) begin
            fifo_mem_q[wr_ptr_q] <= spi_rx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q           <= ST_IDLE;
            cnt_q             <= '0;
            discard_q         <= 1'b0;
            end_pending_q     <= 1'b0;
            restart_pending_q <= 1'b0;
            spi_cs_n_q        <= 4'b1111;
            spi_start_q       <= 1'b0;
            spi_tx_data_q     <= 8'h00;
            i2c_wr_ready_q    <= 1'b0;
            i2c_rd_data_q     <= 8'hFF;
            wr_ptr_q          <= '0;
            rd_ptr_q          <= '0;
            level_q           <= '0;
            overflow_q        <= 1'b0;
        end else begin
            state_q           <= state_d;
            cnt_q             <= cnt_d;
            discard_q         <= discard_d;
            end_pending_q     <= end_pending_d;
            restart_pending_q <= restart_pending_d;
            spi_cs_n_q        <= spi_cs_n_d;
            spi_start_q       <= spi_start_d;
            spi_tx_data_q     <= spi_tx_data_d;
            i2c_wr_ready_q    <= i2c_wr_ready_d;
            i2c_rd_data_q     <= i2c_rd_data_d;
            wr_ptr_q          <= wr_ptr_d;
            rd_ptr_q          <= rd_ptr_d;
            level_q           <= level_d;
            overflow_q        <= overflow_d;
        end
    end

    assign i2c_wr_ready = i2c_wr_ready_q;
    assign i2c_rd_data  = i2c_rd_data_q;
    assign spi_start    = spi_start_q;
    assign spi_tx_data  = spi_tx_data_q;
    assign spi_cs_n     = spi_cs_n_q;
    assign fifo_level   = level_q;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_i2c_spi_bridge_sequencer.sv
// Scoreboard bench for i2c_spi_bridge_sequencer: expected SPI launches and read-back
// bytes are queued by the stimulus and checked by a monitor when the DUT presents them.
module tb_i2c_spi_bridge_sequencer;

    localparam int FD  = 4;
    localparam int CSS = 2;
    localparam int CSH = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i2c_start = 1'b0, i2c_rnw = 1'b0, i2c_stop = 1'b0;
    logic       i2c_wr_valid = 1'b0;
    logic [7:0] i2c_wr_data = 8'h00;
    logic       i2c_wr_ready;
    logic       i2c_rd_req = 1'b0;
    logic [7:0] i2c_rd_data;
    logic       spi_start;
    logic [7:0] spi_tx_data;
    logic       spi_done = 1'b0;
    logic [7:0] spi_rx_data = 8'h00;
    logic [3:0] spi_cs_n;
    logic [$clog2(FD):0] fifo_level;
    logic       overflow;

    always #5 clk = ~clk;

    i2c_spi_bridge_sequencer #(.FIFO_DEPTH(FD), .CS_SETUP(CSS), .CS_HOLD(CSH)) dut (
        .clk(clk), .rst_n(rst_n),
        .i2c_start(i2c_start), .i2c_rnw(i2c_rnw), .i2c_stop(i2c_stop),
        .i2c_wr_valid(i2c_wr_valid), .i2c_wr_data(i2c_wr_data), .i2c_wr_ready(i2c_wr_ready),
        .i2c_rd_req(i2c_rd_req), .i2c_rd_data(i2c_rd_data),
        .spi_start(spi_start), .spi_tx_data(spi_tx_data),
        .spi_done(spi_done), .spi_rx_data(spi_rx_data),
        .spi_cs_n(spi_cs_n), .fifo_level(fifo_level), .overflow(overflow)
    );

    int total_cnt = 0;
    int pass_cnt  = 0;
    int start_cnt = 0;
    logic [7:0] exp_tx_q[$];
    logic [3:0] exp_cs_q[$];
    logic [7:0] exp_rd_q[$];
    logic       rd_seen = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: SPI launches and read-back data are compared against queued expectations
    always @(posedge clk) rd_seen <= i2c_rd_req;

    always @(negedge clk) begin
        if (spi_start) begin
            start_cnt++;
            if (exp_tx_q.size() == 0) begin
                total_cnt++;
                $display("FAIL spi_start_unexpected: got start with tx %0h, none expected", spi_tx_data);
            end else begin
                check("spi_tx_data", spi_tx_data, exp_tx_q.pop_front());
                check("spi_cs_n_at_start", spi_cs_n, exp_cs_q.pop_front());
                $display("xfer launched tx=%0h cs_n=%b", spi_tx_data, spi_cs_n);
            end
        end
        if (rd_seen) begin
            if (exp_rd_q.size() == 0) begin
                total_cnt++;
                $display("FAIL rd_unexpected: got %0h, no read expected", i2c_rd_data);
            end else begin
                check("i2c_rd_data", i2c_rd_data, exp_rd_q.pop_front());
                $display("read-back rd_data=%0h level=%0d", i2c_rd_data, fifo_level);
            end
        end
    end

    task automatic pulse_start(input logic rnw);
        i2c_start = 1'b1; i2c_rnw = rnw;
        @(negedge clk);
        i2c_start = 1'b0; i2c_rnw = 1'b0;
    endtask

    task automatic pulse_stop();
        i2c_stop = 1'b1;
        @(negedge clk);
        i2c_stop = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        while (!i2c_wr_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            total_cnt++;
            $display("FAIL wr_ready_timeout: got ready=0 for 50 cycles, required 1");
        end
        i2c_wr_valid = 1'b1; i2c_wr_data = b;
        @(negedge clk);
        i2c_wr_valid = 1'b0; i2c_wr_data = 8'h00;
    endtask

    task automatic send_data(input logic [7:0] b, input logic [3:0] cs);
        exp_tx_q.push_back(b);
        exp_cs_q.push_back(cs);
        send_byte(b);
    endtask

    task automatic finish_xfer(input logic [7:0] rx, input int delay, input logic [3:0] cs);
        int bad_rdy = 0;
        int bad_cs  = 0;
        for (int i = 0; i < delay; i++) begin
            if (i2c_wr_ready) bad_rdy++;
            if (spi_cs_n !== cs) bad_cs++;
            @(negedge clk);
        end
        spi_done = 1'b1; spi_rx_data = rx;
        @(negedge clk);
        spi_done = 1'b0; spi_rx_data = 8'h00;
        check("wr_ready_low_in_xfer", bad_rdy, 0);
        check("cs_stable_in_xfer", bad_cs, 0);
    endtask

    task automatic xfer(input logic [7:0] b, input logic [7:0] rx, input int delay, input logic [3:0] cs);
        send_data(b, cs);
        finish_xfer(rx, delay, cs);
    endtask

    task automatic rd(input logic [7:0] e);
        exp_rd_q.push_back(e);
        i2c_rd_req = 1'b1;
        @(negedge clk);
        i2c_rd_req = 1'b0;
    endtask

    task automatic wait_cs_high(input string name, input int exp_n);
        int n = 0;
        while (spi_cs_n !== 4'hF && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(name, n, exp_n);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int base;
        repeat (3) @(negedge clk);
        check("rst_cs_n", spi_cs_n, 4'hF);
        check("rst_spi_start", spi_start, 0);
        check("rst_tx_data", spi_tx_data, 0);
        check("rst_wr_ready", i2c_wr_ready, 0);
        check("rst_rd_data", i2c_rd_data, 8'hFF);
        check("rst_level", fifo_level, 0);
        check("rst_overflow", overflow, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single-byte write
        pulse_start(1'b0);
        check("cmd_wr_ready", i2c_wr_ready, 1);
        send_byte(8'h02);
        check("cs_after_ctl_02", spi_cs_n, 4'b1011);
        check("setup_no_ready", i2c_wr_ready, 0);
        base = start_cnt;
        xfer(8'hA5, 8'h3C, 3, 4'b1011);
        check("start_pulse_once", start_cnt - base, 1);
        check("level_after_first", fifo_level, 1);
        check("ready_after_done", i2c_wr_ready, 1);
        pulse_stop();
        wait_cs_high("cs_hold_after_stop", CSH);
        repeat (2) @(negedge clk);
        check("idle_no_ready", i2c_wr_ready, 0);

        // Read-back
        pulse_start(1'b1);
        @(negedge clk);
        check("read_start_no_ready", i2c_wr_ready, 0);
        rd(8'h3C);
        check("level_after_pop", fifo_level, 0);
        rd(8'hFF);
        check("level_after_empty_pop", fifo_level, 0);

        // Discard and back-pressure
        pulse_start(1'b0);
        send_byte(8'h81);
        check("cs_after_ctl_81", spi_cs_n, 4'b1101);
        for (int i = 0; i < 3; i++) begin
            xfer(8'hC0 + 8'(i), 8'hEE, 8, 4'b1101);
            check("discard_level", fifo_level, 0);
        end
        pulse_stop();
        wait_cs_high("cs_hold_discard", CSH);

        // Overflow
        pulse_start(1'b0);
        send_byte(8'h00);
        check("cs_after_ctl_00", spi_cs_n, 4'b1110);
        for (int i = 0; i <= FD; i++) xfer(8'h30 + 8'(i), 8'h10 + 8'(i), 2, 4'b1110);
        check("overflow_set", overflow, 1);
        check("level_full", fifo_level, FD);
        pulse_stop();
        wait_cs_high("cs_hold_overflow", CSH);
        check("overflow_sticky", overflow, 1);
        for (int i = 0; i < FD; i++) rd(8'h10 + 8'(i));
        rd(8'hFF);
        check("level_drained", fifo_level, 0);

        // Stop one cycle after spi_start
        pulse_start(1'b0);
        check("overflow_cleared_in_cmd", overflow, 0);
        send_byte(8'h00);
        send_data(8'h55, 4'b1110);
        @(negedge clk);
        pulse_stop();
        finish_xfer(8'h77, 3, 4'b1110);
        check("no_ready_after_end_done", i2c_wr_ready, 0);
        wait_cs_high("cs_hold_after_done", CSH);
        check("level_after_stop_xfer", fifo_level, 1);
        check("idle_after_stop_xfer", i2c_wr_ready, 0);

        // Repeated start while READY
        pulse_start(1'b0);
        check("cmd_entry_clears_fifo", fifo_level, 0);
        send_byte(8'h02);
        xfer(8'h66, 8'h99, 2, 4'b1011);
        check("level_before_restart", fifo_level, 1);
        pulse_start(1'b0);
        check("hold_no_ready", i2c_wr_ready, 0);
        wait_cs_high("cs_hold_restart", CSH);
        check("restart_cmd_ready", i2c_wr_ready, 1);
        check("restart_fifo_cleared", fifo_level, 0);

        // Reset mid-XFER
        send_byte(8'h03);
        check("cs_after_ctl_03", spi_cs_n, 4'b0111);
        for (int i = 0; i <= FD; i++) xfer(8'h50 + 8'(i), 8'h20 + 8'(i), 1, 4'b0111);
        check("overflow_before_reset", overflow, 1);
        rd(8'h20);
        send_data(8'h42, 4'b0111);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_cs_n", spi_cs_n, 4'hF);
        check("mid_rst_spi_start", spi_start, 0);
        check("mid_rst_tx_data", spi_tx_data, 0);
        check("mid_rst_wr_ready", i2c_wr_ready, 0);
        check("mid_rst_rd_data", i2c_rd_data, 8'hFF);
        check("mid_rst_level", fifo_level, 0);
        check("mid_rst_overflow", overflow, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_idle", i2c_wr_ready, 0);
        check("tx_queue_drained", exp_tx_q.size(), 0);
        check("rd_queue_drained", exp_rd_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
